uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares the single UART byte transmitter between up to four byte-producing clients. Accepts one byte at a time from a requester over a valid/ready handshake, loads it into the transmitter with a one-cycle `tx_load` pulse, and waits for the transmitter's buffer-ready flag to cycle low and back high before arbitrating again. Sits between the command/response engines and the transmitter, on the same clock and reset.

---
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter among NUM_REQ byte producers.
// Optional grant locking is compiled in with `define TX_ARB_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_load,
    input  logic                   tbr,
    output logic [1:0]             grant_id,
    output logic                   busy,
    output logic                   tx_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_cnt;
    logic [7:0]           w_cnt_next;
    logic [7:0]           w_cnt_inc;
    logic                 w_err_next;
    logic [1:0]           r_last;
    logic [7:0]           r_tx_data;
    logic                 r_tx_load;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic                 r_busy;
    logic                 r_tx_err;
    logic                 w_win_found;
    logic [1:0]           w_win_idx;
    logic                 w_grant;
    logic [NUM_REQ-1:0]   w_win_onehot;
    logic [1:0]           w_cand [NUM_REQ];
    logic                 r_lock;

    // Candidate gi is the requester gi+1 places after the last winner.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign w_cand[gi] = 2'((32'(r_last) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
        end
    endgenerate

    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = r_last;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[w_cand[k]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[k];
            end
        end
        if (r_lock) begin
            w_win_found = req_valid[r_last];
            w_win_idx   = r_last;
        end
    end

    assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
    assign w_cnt_inc    = (r_cnt >= 8'(LOAD_TIMEOUT)) ? r_cnt : r_cnt + 8'd1;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tbr && w_win_found) w_state_next = LOAD;
            end
            LOAD: begin
                w_cnt_next   = 8'd0;
                w_state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tbr) begin
                    w_state_next = WAIT_DONE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == 8'(LOAD_TIMEOUT)) begin
                        w_err_next   = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                // No timeout here: frame length depends on the baud rate.
                if (tbr) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_grant = (r_state == IDLE) && (w_state_next == LOAD);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_last      <= 2'(NUM_REQ - 1);
            r_tx_data   <= 8'h00;
            r_tx_load   <= 1'b0;
            r_req_ready <= '0;
            r_busy      <= 1'b0;
            r_tx_err    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_tx_load   <= w_grant;
            r_req_ready <= w_grant ? w_win_onehot : '0;
            r_busy      <= (w_state_next != IDLE);
            r_tx_err    <= w_err_next;
            if (w_grant) begin
                r_tx_data <= req_data[{w_win_idx, 3'b000} +: 8];
                r_last    <= w_win_idx;
            end
        end
    end

`ifdef TX_ARB_LOCK_EN
    // Owner of the lock is always the last winner, so only a flag is stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock <= 1'b0;
        end else if (r_state == LOAD) begin
            r_lock <= req_lock[r_last];
        end else if (w_err_next || !req_lock[r_last]) begin
            r_lock <= 1'b0;
        end
    end
`else
    logic w_unused_lock;
    assign r_lock        = 1'b0;
    assign w_unused_lock = ^req_lock;
`endif

    assign req_ready = r_req_ready;
    assign tx_data   = r_tx_data;
    assign tx_load   = r_tx_load;
    assign grant_id  = r_last;
    assign busy      = r_busy;
    assign tx_err    = r_tx_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter and requester model.
// Expected lock behaviour follows `define TX_ARB_LOCK_EN.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_lock;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        tbr;
    logic [1:0]  grant_id;
    logic        busy;
    logic        tx_err;

    uart_tx_arbiter #(.NUM_REQ(4), .LOAD_TIMEOUT(15)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .tbr       (tbr),
        .grant_id  (grant_id),
        .busy      (busy),
        .tx_err    (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         cnt_q [4];
    logic [7:0] base [4];
    logic [3:0] lock_mode;
    logic       stuck;
    int         frame_len;
    logic       drop_pending;
    int         low_left;
    int         n_tx;
    int         n_err;
    int         err_cyc;
    logic [7:0] log_data [64];
    logic [1:0] log_gid [64];
    int         log_cyc [64];
    int         busy_cyc;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (cnt_q[i] > 0);
            req_data[8*i +: 8] = base[i];
            req_lock[i]        = lock_mode[i] && (cnt_q[i] > 0);
        end
    endtask

    // One clock: observe outputs after the edge, advance models, redrive inputs.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (drop_pending) begin
            tbr = 1'b0;
            low_left = frame_len;
            drop_pending = 1'b0;
        end else if (low_left > 0) begin
            low_left--;
            if (low_left == 0) tbr = 1'b1;
        end
        if (tx_load) begin
            if (n_tx < 64) begin
                log_data[n_tx] = tx_data;
                log_gid[n_tx]  = grant_id;
                log_cyc[n_tx]  = cyc;
            end
            $display("tx %0d: cycle %0d grant_id %0d data 0x%02h", n_tx, cyc, grant_id, tx_data);
            n_tx++;
            if (!stuck) drop_pending = 1'b1;
        end
        if (tx_err) begin
            n_err++;
            err_cyc = cyc;
            $display("tx_err: cycle %0d", cyc);
        end
        for (int i = 0; i < 4; i++)
            if (req_ready[i] && cnt_q[i] > 0) cnt_q[i]--;
        drive_reqs();
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cnt_q[i] = 0;
            base[i]  = 8'h00;
        end
        lock_mode = 4'b0000;
        stuck = 1'b0;
        frame_len = 3;
        drop_pending = 1'b0;
        low_left = 0;
        tbr = 1'b1;
        drive_reqs();
        step();
        step();
        n_tx = 0;
        n_err = 0;
    endtask

    task automatic wait_tx(input int n, input string tag);
        for (int b = 0; b < 300 && n_tx < n; b++) step();
        check_eq(tag, int'(n_tx >= n), 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int b = 0; b < 300 && (busy || cnt_q[0] + cnt_q[1] + cnt_q[2] + cnt_q[3] > 0); b++) step();
        check_eq(tag, int'(busy), 0);
    endtask

    logic [1:0] t2_gid [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] t2_dat [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
`ifdef TX_ARB_LOCK_EN
    logic [1:0] t5_gid [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
`else
    logic [1:0] t5_gid [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
`endif

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        req_lock = '0;
        tbr = 1'b1;

        // Reset values, then a single byte from requester 0.
        assert_reset();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_tx_load", tx_load, 0);
        check_eq("rst_req_ready", req_ready, 0);
        check_eq("rst_grant_id", grant_id, 3);
        check_eq("rst_tx_err", tx_err, 0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        cnt_q[0] = 1;
        base[0]  = 8'hA5;
        drive_reqs();
        reset = 1'b0;
        check_eq("t1_load_first_cycle", tx_load, 0);
        step();
        check_eq("t1_load_second_cycle", tx_load, 1);
        check_eq("t1_tx_data", tx_data, 8'hA5);
        check_eq("t1_req_ready", req_ready, 4'b0001);
        check_eq("t1_grant_id", grant_id, 0);
        busy_cyc = busy ? 1 : 0;
        step();
        check_eq("t1_load_one_cycle", tx_load, 0);
        check_eq("t1_ready_one_cycle", req_ready, 0);
        for (int b = 0; b < 30 && busy; b++) begin
            if (busy) busy_cyc++;
            step();
        end
        check_eq("t1_busy_cycles", busy_cyc, 5);
        check_eq("t1_tbr_back", tbr, 1);

        // Round robin across four continuously valid requesters.
        assert_reset();
        for (int i = 0; i < 4; i++) begin
            cnt_q[i] = 2;
            base[i]  = 8'h10 + 8'(i);
        end
        drive_reqs();
        reset = 1'b0;
        wait_tx(5, "t2_five_loads");
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t2_data_%0d", k), log_data[k], t2_dat[k]);
            check_eq($sformatf("t2_gid_%0d", k), log_gid[k], t2_gid[k]);
        end
        wait_idle("t2_drain");

        // Transmitter never takes the byte: timeout, then the next request is served.
        assert_reset();
        stuck = 1'b1;
        base[0] = 8'h30;
        base[1] = 8'h31;
        cnt_q[0] = 1;
        cnt_q[1] = 1;
        drive_reqs();
        reset = 1'b0;
        for (int b = 0; b < 100 && n_err == 0; b++) step();
        stuck = 1'b0;
        check_eq("t3_err_seen", n_err, 1);
        check_eq("t3_err_delay", err_cyc - log_cyc[0], 16);
        wait_tx(2, "t3_next_load");
        wait_idle("t3_drain");
        check_eq("t3_err_count", n_err, 1);
        check_eq("t3_next_gid", log_gid[1], 1);
        check_eq("t3_next_data", log_data[1], 8'h31);

        // Reset while waiting for the frame to finish.
        assert_reset();
        frame_len = 20;
        base[0] = 8'h40;
        cnt_q[0] = 1;
        drive_reqs();
        reset = 1'b0;
        wait_tx(1, "t4_first_load");
        step();
        step();
        step();
        check_eq("t4_busy_before", busy, 1);
        reset = 1'b1;
        step();
        check_eq("t4_busy_after_rst", busy, 0);
        check_eq("t4_load_after_rst", tx_load, 0);
        check_eq("t4_ready_after_rst", req_ready, 0);
        check_eq("t4_err_after_rst", tx_err, 0);
        step();
        drop_pending = 1'b0;
        low_left = 0;
        tbr = 1'b1;
        frame_len = 3;
        base[2] = 8'h42;
        cnt_q[0] = 1;
        cnt_q[2] = 1;
        drive_reqs();
        reset = 1'b0;
        n_tx = 0;
        wait_tx(1, "t4_load_after_rst");
        check_eq("t4_first_gid", log_gid[0], 0);
        check_eq("t4_first_data", log_data[0], 8'h40);
        wait_idle("t4_drain");

        // Requester 1 holds req_lock while requester 0 competes.
        assert_reset();
        lock_mode[1] = 1'b1;
        base[0] = 8'h50;
        base[1] = 8'h51;
        cnt_q[1] = 3;
        drive_reqs();
        reset = 1'b0;
        wait_tx(1, "t5_first_load");
        cnt_q[0] = 2;
        drive_reqs();
        wait_tx(4, "t5_four_loads");
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t5_gid_%0d", k), log_gid[k], t5_gid[k]);
            check_eq($sformatf("t5_data_%0d", k), log_data[k], 8'h50 + 8'(t5_gid[k]));
        end
        wait_idle("t5_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
